// File: rtl/global_pkg.sv
// Project-wide constants shared by datapath blocks.
package global_pkg;
   localparam int   DW   = 4;
   localparam int   DW_2 = 2 * DW;
   localparam logic ONE  = 1'b1;
   localparam logic ZERO = 1'b0;
endpackage

// File: rtl/mult_arbiter_pkg.sv
// State encoding, default timeout and timer sizing for the multiplier arbiter.
package mult_arbiter_pkg;
   localparam int TIMEOUT_DEF = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   // Timer only needs to hold TIMEOUT-1.
   function automatic int tmr_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction
endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, result and shared-multiplier signals of the multiplier arbiter.
interface mult_arbiter_if #(
   parameter int DW = global_pkg::DW
);
   localparam int DW_2 = 2 * DW;

   logic            req_0;
   logic            req_1;
   logic [DW-1:0]   a_0;
   logic [DW-1:0]   b_0;
   logic [DW-1:0]   a_1;
   logic [DW-1:0]   b_1;
   logic            gnt_0;
   logic            gnt_1;

   logic            mul_start;
   logic [DW-1:0]   mul_multiplier;
   logic [DW-1:0]   mul_multiplicand;
   logic            mul_done;
   logic            mul_sign;
   logic [DW_2-1:0] mul_product;

   logic            res_valid;
   logic            res_id;
   logic            res_sign;
   logic [DW_2-1:0] res_product;
   logic            res_err;

   // slave: the arbiter; master: requesters plus the multiplier
   modport slave (
      input  req_0, req_1, a_0, b_0, a_1, b_1,
      input  mul_done, mul_sign, mul_product,
      output gnt_0, gnt_1,
      output mul_start, mul_multiplier, mul_multiplicand,
      output res_valid, res_id, res_sign, res_product, res_err
   );

   modport master (
      output req_0, req_1, a_0, b_0, a_1, b_1,
      output mul_done, mul_sign, mul_product,
      input  gnt_0, gnt_1,
      input  mul_start, mul_multiplier, mul_multiplicand,
      input  res_valid, res_id, res_sign, res_product, res_err
   );
endinterface

// File: rtl/mult_arbiter_rr_select_2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
module rr_select_2
   import global_pkg::*;
(
   input  logic req_0,
   input  logic req_1,
   input  logic last,
   output logic winner
);

   always_comb begin
      winner = ZERO;
      if (req_0 && req_1) begin
         winner = ~last;
      end else if (req_1) begin
         winner = ONE;
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared signed multiplier, with a timeout abort.
//
// state | meaning
// IDLE  | no operation; a request seen on an edge is granted next cycle
// ISSUE | gnt_k and mul_start pulse together; operands now held
// WAIT  | timer runs until mul_done or terminal count
// RESP  | res_valid pulse; last-served takes res_id
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int DW      = global_pkg::DW,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mult_arbiter_if.slave bus
);

   localparam int             PW       = 2 * DW;
   localparam int             TW       = tmr_width(TIMEOUT);
   localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            gnt_0_q, gnt_0_d;
   logic            gnt_1_q, gnt_1_d;
   logic            mul_start_q, mul_start_d;
   logic [DW-1:0]   mul_a_q, mul_a_d;
   logic [DW-1:0]   mul_b_q, mul_b_d;
   logic            res_valid_q, res_valid_d;
   logic            res_id_q, res_id_d;
   logic            res_sign_q, res_sign_d;
   logic [PW-1:0]   res_product_q, res_product_d;
   logic            res_err_q, res_err_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            last_q, last_d;
   logic            winner;

   rr_select_2 u_rr_select_2 (
      .req_0  (bus.req_0),
      .req_1  (bus.req_1),
      .last   (last_q),
      .winner (winner)
   );

   always_comb begin
      state_d       = state_q;
      gnt_0_d       = 1'b0;
      gnt_1_d       = 1'b0;
      mul_start_d   = 1'b0;
      res_valid_d   = 1'b0;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      res_id_d      = res_id_q;
      res_sign_d    = res_sign_q;
      res_product_d = res_product_q;
      res_err_d     = res_err_q;
      tmr_d         = tmr_q;
      last_d        = last_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_0 || bus.req_1) begin
               state_d     = ST_ISSUE;
               gnt_0_d     = ~winner;
               gnt_1_d     = winner;
               mul_start_d = 1'b1;
               mul_a_d     = winner ? bus.a_1 : bus.a_0;
               mul_b_d     = winner ? bus.b_1 : bus.b_0;
               res_id_d    = winner;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            tmr_d   = TMR_LOAD;
         end
         ST_WAIT: begin
            // A done arriving on the terminal-count cycle still wins.
            if (bus.mul_done) begin
               state_d       = ST_RESP;
               res_valid_d   = 1'b1;
               res_sign_d    = bus.mul_sign;
               res_product_d = bus.mul_product;
               res_err_d     = 1'b0;
            end else if (tmr_q == '0) begin
               state_d       = ST_RESP;
               res_valid_d   = 1'b1;
               res_sign_d    = 1'b0;
               res_product_d = '0;
               res_err_d     = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            last_d  = res_id_q;
            tmr_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         gnt_0_q       <= 1'b0;
         gnt_1_q       <= 1'b0;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         res_valid_q   <= 1'b0;
         res_id_q      <= 1'b0;
         res_sign_q    <= 1'b0;
         res_product_q <= '0;
         res_err_q     <= 1'b0;
         tmr_q         <= '0;
         last_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         gnt_0_q       <= gnt_0_d;
         gnt_1_q       <= gnt_1_d;
         mul_start_q   <= mul_start_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         res_valid_q   <= res_valid_d;
         res_id_q      <= res_id_d;
         res_sign_q    <= res_sign_d;
         res_product_q <= res_product_d;
         res_err_q     <= res_err_d;
         tmr_q         <= tmr_d;
         last_q        <= last_d;
      end
   end

   assign bus.gnt_0            = gnt_0_q;
   assign bus.gnt_1            = gnt_1_q;
   assign bus.mul_start        = mul_start_q;
   assign bus.mul_multiplier   = mul_a_q;
   assign bus.mul_multiplicand = mul_b_q;
   assign bus.res_valid        = res_valid_q;
   assign bus.res_id           = res_id_q;
   assign bus.res_sign         = res_sign_q;
   assign bus.res_product      = res_product_q;
   assign bus.res_err          = res_err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 4-cycle behavioural multiplier and a result scoreboard.
module tb_mult_arbiter;
   import global_pkg::*;

   localparam int TMO = 16;
   // gnt edge to res_valid edge: start sampled +1, done high 4 cycles after start, sampled +5
   localparam int LAT = 5;

   typedef struct packed {
      logic          id;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } iss_t;

   typedef struct packed {
      logic            id;
      logic            sign;
      logic [DW_2-1:0] prod;
      logic            err;
      int              lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0, n_fail = 0, cyc = 0;
   int   n_gnt = 0, n_res = 0, gnt_cyc = 0, res_cyc = 0;
   iss_t iss_q[$];
   exp_t exp_q[$];
   iss_t cur = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_arbiter_if #(.DW(DW)) bus ();

   mult_arbiter #(.DW(DW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // behavioural multiplier: done pulses 4 cycles after the start cycle
   logic                   hang = 1'b0, stray = 1'b0, model_done = 1'b0;
   logic [2:0]             mcnt = 3'd0;
   logic [DW_2-1:0]        mprod = '0;
   logic signed [DW_2-1:0] ma, mb;
   assign ma              = DW_2'($signed(bus.mul_multiplier));
   assign mb              = DW_2'($signed(bus.mul_multiplicand));
   assign bus.mul_done    = model_done | stray;
   assign bus.mul_sign    = mprod[DW_2-1];
   assign bus.mul_product = mprod;

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (bus.mul_start && !hang) begin
         mcnt  <= 3'd3;
         mprod <= ma * mb;
      end else if (mcnt != 3'd0) begin
         mcnt <= mcnt - 3'd1;
         if (mcnt == 3'd1) model_done <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({bus.gnt_0, bus.gnt_1, bus.mul_start, bus.mul_multiplier, bus.mul_multiplicand,
                  bus.res_valid, bus.res_id, bus.res_sign, bus.res_product, bus.res_err});
   endfunction

   task automatic report();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
   endtask

   // monitor: grants against the issue queue, results against the expected queue
   always @(negedge clk) begin
      if (rst) begin
         if (bus.gnt_0 || bus.gnt_1 || bus.mul_start) begin
            check("start_with_gnt", 32'({bus.mul_start, bus.gnt_0 ^ bus.gnt_1}), 32'd3);
            if (iss_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_gnt: got gnt_0=%0b gnt_1=%0b, expected none", bus.gnt_0, bus.gnt_1);
            end else begin
               cur = iss_q.pop_front();
               check("gnt_id", 32'(bus.gnt_1), 32'(cur.id));
               check("operand_a", 32'(bus.mul_multiplier), 32'(cur.a));
               check("operand_b", 32'(bus.mul_multiplicand), 32'(cur.b));
            end
            gnt_cyc = cyc;
            n_gnt++;
         end
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_res: got res_valid id=%0b, expected none", bus.res_id);
            end else begin
               automatic exp_t e = exp_q.pop_front();
               check("res_id", 32'(bus.res_id), 32'(e.id));
               check("res_sign", 32'(bus.res_sign), 32'(e.sign));
               check("res_product", 32'(bus.res_product), 32'(e.prod));
               check("res_err", 32'(bus.res_err), 32'(e.err));
               check("operands_held", 32'({bus.mul_multiplier, bus.mul_multiplicand}), 32'({cur.a, cur.b}));
               if (e.lat >= 0) check("latency", 32'(cyc - gnt_cyc), 32'(e.lat));
            end
            res_cyc = cyc;
            n_res++;
         end
      end
   end

   task automatic wait_gnt(input int target, input int max_cyc, input string name);
      int i = 0;
      while (n_gnt < target && i < max_cyc) begin
         @(negedge clk);
         #1;
         i++;
      end
      check(name, 32'(n_gnt >= target), 32'd1);
   endtask

   task automatic wait_res(input int target, input int max_cyc, input string name);
      int i = 0;
      while (n_res < target && i < max_cyc) begin
         @(negedge clk);
         #1;
         i++;
      end
      check(name, 32'(n_res >= target), 32'd1);
   endtask

   task automatic set_req(input logic k, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (k) begin
         bus.req_1 = v; bus.a_1 = a; bus.b_1 = b;
      end else begin
         bus.req_0 = v; bus.a_0 = a; bus.b_0 = b;
      end
   endtask

   task automatic op(input logic k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic sign, input logic [DW_2-1:0] prod, input logic err, input int lat);
      int g = n_gnt + 1;
      int r = n_res + 1;
      iss_q.push_back('{id: k, a: a, b: b});
      exp_q.push_back('{id: k, sign: sign, prod: prod, err: err, lat: lat});
      @(posedge clk); #1;
      set_req(k, 1'b1, a, b);
      wait_gnt(g, 10, "gnt_arrives");
      set_req(k, 1'b0, a, b);
      wait_res(r, TMO + 10, "res_arrives");
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
      report();
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g, r;
      set_req(1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs(), 32'd0);
      @(negedge clk) rst = 1'b1;

      // tie straight after reset: 0 first (6), then 1 (7 x -4 = -28)
      g = n_gnt; r = n_res;
      iss_q.push_back('{id: 1'b0, a: 4'b0010, b: 4'b0011});
      iss_q.push_back('{id: 1'b1, a: 4'b0111, b: 4'b1100});
      exp_q.push_back('{id: 1'b0, sign: 1'b0, prod: 8'h06, err: 1'b0, lat: LAT});
      exp_q.push_back('{id: 1'b1, sign: 1'b1, prod: 8'hE4, err: 1'b0, lat: LAT});
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'b0010, 4'b0011);
      set_req(1'b1, 1'b1, 4'b0111, 4'b1100);
      wait_gnt(g + 1, 10, "tie_gnt_first");
      set_req(1'b0, 1'b0, 4'b0010, 4'b0011);
      wait_gnt(g + 2, 20, "tie_gnt_second");
      set_req(1'b1, 1'b0, 4'b0111, 4'b1100);
      wait_res(r + 2, 20, "tie_results");

      // fairness: both held for six operations, ids alternate 0,1,0,1,0,1
      g = n_gnt; r = n_res;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            iss_q.push_back('{id: 1'b0, a: 4'b0010, b: 4'b0011});
            exp_q.push_back('{id: 1'b0, sign: 1'b0, prod: 8'h06, err: 1'b0, lat: LAT});
         end else begin
            iss_q.push_back('{id: 1'b1, a: 4'b1110, b: 4'b0011});
            exp_q.push_back('{id: 1'b1, sign: 1'b1, prod: 8'hFA, err: 1'b0, lat: LAT});
         end
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'b0010, 4'b0011);
      set_req(1'b1, 1'b1, 4'b1110, 4'b0011);
      wait_gnt(g + 6, 80, "fair_gnts");
      set_req(1'b0, 1'b0, 4'b0010, 4'b0011);
      set_req(1'b1, 1'b0, 4'b1110, 4'b0011);
      wait_res(r + 6, 20, "fair_results");

      // single request: 7 x -1 = -7
      op(1'b0, 4'b0111, 4'b1111, 1'b1, 8'hF9, 1'b0, LAT);

      // timeout: res_valid TMO+2 edges after the request edge, i.e. TMO+1 after the gnt edge
      hang = 1'b1;
      op(1'b1, 4'b0011, 4'b0011, 1'b0, 8'h00, 1'b1, TMO + 1);
      hang = 1'b0;

      // busy-time request: req_1 raised in WAIT of a requester-0 operation
      g = n_gnt; r = n_res;
      iss_q.push_back('{id: 1'b0, a: 4'b0101, b: 4'b0101});
      iss_q.push_back('{id: 1'b1, a: 4'b1111, b: 4'b1111});
      exp_q.push_back('{id: 1'b0, sign: 1'b0, prod: 8'h19, err: 1'b0, lat: LAT});
      exp_q.push_back('{id: 1'b1, sign: 1'b0, prod: 8'h01, err: 1'b0, lat: LAT});
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'b0101, 4'b0101);
      wait_gnt(g + 1, 10, "busy_gnt_0");
      set_req(1'b0, 1'b0, 4'b0101, 4'b0101);
      repeat (2) @(posedge clk);
      #1;
      set_req(1'b1, 1'b1, 4'b1111, 4'b1111);
      wait_res(r + 1, 20, "busy_res_0");
      wait_gnt(g + 2, 10, "busy_gnt_1");
      check("busy_gnt_timing", 32'(gnt_cyc - res_cyc), 32'd2);
      set_req(1'b1, 1'b0, 4'b1111, 4'b1111);
      wait_res(r + 2, 20, "busy_res_1");

      // stray mul_done while idle
      r = n_res;
      @(posedge clk); #1 stray = 1'b1;
      @(posedge clk); #1 stray = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("stray_done_ignored", 32'(n_res), 32'(r));

      // reset two cycles after mul_start abandons the operation
      g = n_gnt; r = n_res;
      iss_q.push_back('{id: 1'b0, a: 4'b0011, b: 4'b0011});
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 4'b0011, 4'b0011);
      wait_gnt(g + 1, 10, "abort_gnt");
      set_req(1'b0, 1'b0, 4'b0011, 4'b0011);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_async_outputs", outs(), 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("no_res_after_abort", 32'(n_res), 32'(r));

      // after release: -6 x 5 = -30
      op(1'b1, 4'b1010, 4'b0101, 1'b1, 8'hE2, 1'b0, LAT);

      repeat (4) @(posedge clk);
      #1;
      check("queues_drained", 32'(exp_q.size() + iss_q.size()), 32'd0);
      report();
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter DW, default 4: operand width; SHALL take its value from the shared global package.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent waiting for mul_done before abort.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_0, req_1  input  1 each  requester k asks for a multiply; held high until gnt_k.
REQ-006 a_0, b_0, a_1, b_1  input  DW each  multiplier/multiplicand operands of requester k, valid while req_k is high.
REQ-007 gnt_0, gnt_1  output  1 each  one-cycle pulse: requester k's operands are captured.
REQ-008 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-009 mul_multiplier, mul_multiplicand  output  DW each  registered operands driven to the multiplier.
REQ-010 mul_done  input  1  multiplier result-ready pulse.
REQ-011 mul_sign, mul_product  input  1, 2*DW  multiplier result.
REQ-012 res_valid  output  1  one-cycle pulse: result fields are valid.
REQ-013 res_id  output  1  index of the requester owning the result.
REQ-014 res_sign, res_product  output  1, 2*DW  result, passed through unchanged from the multiplier.
REQ-015 res_err  output  1  high with res_valid when the operation timed out.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; every output SHALL be registered.
REQ-017 IDLE: if any req_k is high at a clock edge, the FSM SHALL go to ISSUE; in the following cycle it SHALL pulse gnt_k, capture a_k/b_k into mul_multiplier/mul_multiplicand, and record res_id=k.
REQ-018 Arbitration: a single request wins. When req_0 and req_1 are both high, the requester not served last SHALL win (round-robin). After reset, last-served SHALL be 1, so requester 0 wins the first tie.
REQ-019 ISSUE: mul_start SHALL be high for exactly one cycle, coincident with gnt_k; the next state SHALL be WAIT.
REQ-020 WAIT: the timeout counter SHALL clear on WAIT entry and increment every cycle. When mul_done is sampled high, the block SHALL latch mul_sign/mul_product, set res_err=0 and go to RESP.
REQ-021 Timeout: if the counter reaches TIMEOUT-1 without mul_done, the block SHALL set res_sign=0, res_product=0, res_err=1 and go to RESP.
REQ-022 RESP: res_valid SHALL be high for exactly one cycle; the next state SHALL be IDLE; last-served SHALL update to res_id.
REQ-023 Requests arriving in ISSUE, WAIT or RESP SHALL be ignored until IDLE; there SHALL be no queueing.
REQ-024 mul_done seen outside WAIT SHALL be ignored.
REQ-025 Minimum latency from request edge to res_valid SHALL be: 1 (IDLE→ISSUE) + 1 (ISSUE) + multiplier latency + 1 (RESP).
REQ-026 Operands SHALL stay stable on mul_multiplier/mul_multiplicand from ISSUE through RESP.

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE; all outputs 0; counter 0; last-served 1.
REQ-028 Reset asserted mid-operation SHALL abandon the operation without producing res_valid; operation after release SHALL be as from power-up.

Structure
REQ-029 DW, DW_2=2*DW, ONE and ZERO SHALL come from the shared global package. The FSM state enum and TIMEOUT default SHALL live in a new package, Pkg_Mult_Arbiter.
REQ-030 The round-robin winner selection SHALL be a sub-module, rr_select_2 (inputs req_0, req_1, last; output winner).
REQ-031 Integration: instantiate the existing signed multiplier as the shared resource behind mul_* ports. No multiplier logic SHALL be placed inside this block.

Verification (bench uses a behavioural multiplier model: mul_done 4 cycles after mul_start)
REQ-032 Single request: req_0=1, a_0=4'b0111, b_0=4'b1111 → gnt_0 pulse, mul_start pulse, res_valid with res_id=0, res_err=0 and the model's result for 7×(-1).
REQ-033 Tie after reset: req_0=req_1=1 → requester 0 served first, then requester 1 (a_1=4'b0111, b_1=4'b1100); result res_id sequence is 0, 1.
REQ-034 Fairness: both requests held high for 6 operations → res_id sequence 0,1,0,1,0,1.
REQ-035 Timeout: model never raises mul_done → res_valid with res_err=1 and res_product=0 at TIMEOUT+2 cycles after the request edge.
REQ-036 Reset mid-WAIT: rst driven low 2 cycles after mul_start → all outputs 0 immediately, no res_valid; after release, req_1 with 4'b1010×4'b0101 completes normally.
REQ-037 Busy-time request: req_1 raised during WAIT of a requester-0 operation → no gnt_1 until IDLE; gnt_1 one cycle after the RESP cycle.
